// File: rtl/fibo_host_controller_if.sv
// Bus bundle for fibo_host_controller: upstream request, downstream response
// and the begin_fibo/done calculator port.
interface fibo_host_controller_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_index;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_value;
  logic        rsp_error;
  logic [4:0]  input_s;
  logic        begin_fibo;
  logic [15:0] fibo_out;
  logic        done;

  // Controller side.
  modport master (
    input  req_valid, req_index, rsp_ready, fibo_out, done,
    output req_ready, rsp_valid, rsp_value, rsp_error, input_s, begin_fibo
  );

  // Requester / response sink / calculator side.
  modport slave (
    output req_valid, req_index, rsp_ready, fibo_out, done,
    input  req_ready, rsp_valid, rsp_value, rsp_error, input_s, begin_fibo
  );
endinterface

// File: rtl/fibo_host_controller.sv
// Sequences one Fibonacci request at a time through the begin_fibo/done
// calculator. Optional WAIT watchdog is enabled by defining FIBO_TIMEOUT_EN.
module fibo_host_controller #(
  parameter int BEGIN_HOLD     = 2,
  parameter int MAX_INDEX      = 24,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  fibo_host_controller_if.master   bus,
  output logic                     busy_o,
  output logic [CNT_W-1:0]         rsp_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int          HOLD_W    = (BEGIN_HOLD > 1) ? $clog2(BEGIN_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(BEGIN_HOLD - 1);
  localparam logic [4:0]  MAX_IDX   = 5'(MAX_INDEX);
  localparam logic [15:0] ERR_VALUE = 16'hFFFF;

  if (BEGIN_HOLD < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("fibo_host_controller: BEGIN_HOLD and TIMEOUT_CYCLES must be >= 1");
  end

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [4:0]          input_s_q, input_s_d;
  logic [15:0]         value_q, value_d;
  logic                error_q, error_d;
  logic [CNT_W-1:0]    count_q, count_d;

`ifdef FIBO_TIMEOUT_EN
  localparam int            TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0]     wait_cnt_q, wait_cnt_d;
`endif

  // NOTE: every variable driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    input_s_d = input_s_q;
    value_d   = value_q;
    error_d   = error_q;
    count_d   = count_q;
`ifdef FIBO_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_index <= MAX_IDX) begin
            input_s_d = bus.req_index;
            hold_d    = '0;
            state_d   = ST_ISSUE;
          end else begin
            // Out-of-range index is answered directly; calculator untouched.
            value_d = ERR_VALUE;
            error_d = 1'b1;
            state_d = ST_RESP;
          end
        end
      end

      ST_ISSUE: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_WAIT;
`ifdef FIBO_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      ST_WAIT: begin
        if (bus.done) begin
          value_d = bus.fibo_out;
          error_d = 1'b0;
          state_d = ST_RESP;
        end
`ifdef FIBO_TIMEOUT_EN
        else if (wait_cnt_q == TO_LAST) begin
          value_d = ERR_VALUE;
          error_d = 1'b1;
          state_d = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
`endif
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
          if (count_q != '1) count_d = count_q + CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == ST_IDLE);
    bus.rsp_valid  = (state_q == ST_RESP);
    bus.begin_fibo = (state_q == ST_ISSUE);
    bus.rsp_value  = value_q;
    bus.rsp_error  = error_q;
    bus.input_s    = input_s_q;
    busy_o         = (state_q != ST_IDLE);
    rsp_count_o    = count_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      input_s_q <= '0;
      value_q   <= '0;
      error_q   <= 1'b0;
      count_q   <= '0;
`ifdef FIBO_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      input_s_q <= input_s_d;
      value_q   <= value_d;
      error_q   <= error_d;
      count_q   <= count_d;
`ifdef FIBO_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_fibo_host_controller.sv
// Directed bench for fibo_host_controller with a fixed-latency calculator model.
module tb_fibo_host_controller;
  localparam int CALC_LAT = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       busy;
  logic [7:0] rsp_count;
  int         checks = 0;
  int         failures = 0;
  bit         calc_respond = 1'b1;

  fibo_host_controller_if bus();

  fibo_host_controller #(
    .BEGIN_HOLD(2), .MAX_INDEX(24), .TIMEOUT_CYCLES(16), .CNT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .busy_o(busy), .rsp_count_o(rsp_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] fib(input logic [4:0] n);
    logic [31:0] a, b, t;
    a = 0; b = 1;
    for (int i = 0; i < int'(n); i++) begin t = a + b; a = b; b = t; end
    return a[15:0];
  endfunction

  // Calculator: restarts on each rising begin_fibo, drops done while busy.
  initial begin : calc_model
    logic       begin_prev;
    logic [4:0] calc_idx;
    int         calc_cnt;
    bit         calc_active;
    begin_prev = 1'b0; calc_idx = '0; calc_cnt = 0; calc_active = 1'b0;
    bus.done = 1'b0; bus.fibo_out = '0;
    forever begin
      @(negedge clk);
      if (bus.begin_fibo === 1'b1 && !begin_prev) begin
        calc_idx = bus.input_s; calc_cnt = 0; calc_active = 1'b1; bus.done = 1'b0;
      end else if (calc_active) begin
        calc_cnt++;
        if (calc_cnt == CALC_LAT) begin
          calc_active = 1'b0;
          if (calc_respond) begin bus.fibo_out = fib(calc_idx); bus.done = 1'b1; end
        end
      end
      begin_prev = (bus.begin_fibo === 1'b1);
    end
  end

  task automatic transact(input logic [4:0] idx, input logic [15:0] exp_val, input logic exp_err,
                          input int exp_begins, input int exp_wait, input int stall);
    int begins, waited;
    bit in_ok, stable;
    logic [15:0] v0;
    logic e0;
    begins = 0; waited = 0; in_ok = 1'b1; stable = 1'b1;
    bus.req_index = idx; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    while (!bus.rsp_valid && waited < 200) begin
      if (bus.begin_fibo) begin
        begins++;
        if (bus.input_s !== idx) in_ok = 1'b0;
      end
      @(negedge clk);
      waited++;
    end
    check("rsp_seen", 32'(waited < 200), 1);
    check("begin_cycles", begins, exp_begins);
    if (exp_begins > 0) check("input_s_during_begin", in_ok, 1);
    if (exp_wait >= 0) check("rsp_latency", waited, exp_wait);
    check("rsp_value", bus.rsp_value, exp_val);
    check("rsp_error", bus.rsp_error, exp_err);
    check("req_ready_in_resp", bus.req_ready, 0);
    check("busy_in_resp", busy, 1);
    v0 = bus.rsp_value; e0 = bus.rsp_error;
    repeat (stall) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_value !== v0 || bus.rsp_error !== e0 ||
          bus.req_ready !== 1'b0) stable = 1'b0;
    end
    if (stall > 0) check("rsp_stable_under_stall", stable, 1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_dropped", bus.rsp_valid, 0);
    check("idle_req_ready", bus.req_ready, 1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin : stimulus
    int  waited;
    bit  flag;

    bus.req_valid = 1'b0; bus.req_index = '0; bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_req_ready", bus.req_ready, 1);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_rsp_error", bus.rsp_error, 0);
    check("reset_rsp_value", bus.rsp_value, 0);
    check("reset_input_s", bus.input_s, 0);
    check("reset_begin", bus.begin_fibo, 0);
    check("reset_busy", busy, 0);
    check("reset_count", rsp_count, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single request, index 5.
    transact(5'd5, 16'd5, 1'b0, 2, 7, 0);
    check("count_after_5", rsp_count, 1);

    // Back-to-back 9 then 12 with rsp_ready held high.
    bus.rsp_ready = 1'b1; bus.req_index = 5'd9; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_index = 5'd12;
    flag = 1'b1; waited = 0;
    while (!bus.rsp_valid && waited < 200) begin
      if (bus.req_ready) flag = 1'b0;
      @(negedge clk); waited++;
    end
    check("b2b_first_value", bus.rsp_value, 34);
    check("b2b_no_early_accept", flag, 1);
    check("b2b_ready_in_handshake", bus.req_ready, 0);
    @(negedge clk);
    check("b2b_idle_after_hs", bus.req_ready, 1);
    check("b2b_count_first", rsp_count, 2);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("b2b_second_issue", bus.begin_fibo, 1);
    check("b2b_second_input_s", bus.input_s, 12);
    waited = 0;
    while (!bus.rsp_valid && waited < 200) begin @(negedge clk); waited++; end
    check("b2b_second_value", bus.rsp_value, 144);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("b2b_count_second", rsp_count, 3);

    // Range boundaries.
    transact(5'd25, 16'hFFFF, 1'b1, 0, 0, 0);
    check("range_input_s_kept", bus.input_s, 12);
    check("count_after_25", rsp_count, 4);
    transact(5'd24, 16'd46368, 1'b0, 2, 7, 0);
    transact(5'd0, 16'd0, 1'b0, 2, 7, 0);
    transact(5'd1, 16'd1, 1'b0, 2, 7, 0);
    check("count_after_24_0_1", rsp_count, 7);

    // Downstream stall for 10 cycles.
    transact(5'd9, 16'd34, 1'b0, 2, 7, 10);
    check("count_after_stall", rsp_count, 8);

    // Reset during WAIT for index 12.
    bus.req_index = 5'd12; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_in_wait_begin", bus.begin_fibo, 0);
    check("abort_in_wait_busy", busy, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_begin_low", bus.begin_fibo, 0);
    check("abort_busy_low", busy, 0);
    check("abort_no_rsp", bus.rsp_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    flag = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) flag = 1'b0;
    end
    check("abort_quiet_after", flag, 1);
    check("abort_count_cleared", rsp_count, 0);
    transact(5'd5, 16'd5, 1'b0, 2, 7, 0);
    check("count_after_abort", rsp_count, 1);

    // Counter saturation with streaming range errors.
    bus.rsp_ready = 1'b1; bus.req_index = 5'd31; bus.req_valid = 1'b1;
    repeat (600) @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("count_saturated", rsp_count, 8'hFF);

    // Calculator that never finishes.
    calc_respond = 1'b0;
`ifdef FIBO_TIMEOUT_EN
    transact(5'd12, 16'hFFFF, 1'b1, 2, 18, 0);
    check("timeout_count_held", rsp_count, 8'hFF);
`else
    bus.req_index = 5'd12; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    flag = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (busy !== 1'b1 || bus.rsp_valid !== 1'b0) flag = 1'b0;
    end
    check("hang_busy_held", flag, 1);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("hang_reset_idle", busy, 0);
`endif
    calc_respond = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
